// File: rtl/data_memory_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_mp_if
// Brief    : Read/write/control bundle for the multi-port data memory.
// Revision : 1.0
// ============================================================================
interface data_memory_mp_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_PORTS   = 4,
    parameter int WR_PORTS   = 4
);
    logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr;
    logic [RD_PORTS*DATA_WIDTH-1:0] rd_data;
    logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr;
    logic [WR_PORTS*DATA_WIDTH-1:0] wr_data;
    logic [WR_PORTS-1:0]            wr_en;
    logic                           clear_req;
    logic                           ready;
    logic                           wr_conflict;
    logic                           err_oob;
    logic                           err_clr;

    modport master (
        output rd_addr, wr_addr, wr_data, wr_en, clear_req, err_clr,
        input  rd_data, ready, wr_conflict, err_oob
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, wr_en, clear_req, err_clr,
        output rd_data, ready, wr_conflict, err_oob
    );
endinterface
`default_nettype wire

// File: rtl/data_memory_mp.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_mp
// Brief    : Multi-port data memory with clear sequencer, write-collision
//            priority, conflict pulse and sticky out-of-range write error.
// Revision : 1.0
// ============================================================================
module data_memory_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_PORTS   = 4,
    parameter int WR_PORTS   = 4
) (
    input  logic             clock,
    input  logic             reset,
    data_memory_mp_if.slave  bus
);

    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic [ADDR_WIDTH-1:0]   w_clr_ptr_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    r_conflict;
    logic                    r_err_oob;

    logic [ADDR_WIDTH-1:0]   w_wr_addr [WR_PORTS];
    logic [IDX_W-1:0]        w_wr_idx  [WR_PORTS];
    logic [DATA_WIDTH-1:0]   w_wr_data [WR_PORTS];
    logic [WR_PORTS-1:0]     w_wr_ok;
    logic [WR_PORTS-1:0]     w_wr_oob;
    logic                    w_collision;
    logic                    w_oob_any;
    logic                    w_is_ready;

    assign w_is_ready = (r_state == ST_READY);

    generate
        for (genvar p = 0; p < WR_PORTS; p++) begin : g_wr_port
            assign w_wr_addr[p] = bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wr_idx[p]  = w_wr_addr[p][IDX_W-1:0];
            assign w_wr_data[p] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
            assign w_wr_ok[p]   = bus.wr_en[p] &&  ({1'b0, w_wr_addr[p]} < c_DEPTH);
            assign w_wr_oob[p]  = bus.wr_en[p] && !({1'b0, w_wr_addr[p]} < c_DEPTH);
        end
    endgenerate

    // Any pair of enabled in-range ports hitting the same word is a collision.
    always_comb begin
        w_collision = 1'b0;
        for (int i = 0; i < WR_PORTS; i++) begin
            for (int j = i + 1; j < WR_PORTS; j++) begin
                if (w_wr_ok[i] && w_wr_ok[j] && (w_wr_addr[i] == w_wr_addr[j])) begin
                    w_collision = 1'b1;
                end
            end
        end
    end

    assign w_oob_any = |w_wr_oob;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_ptr == c_LAST) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + ADDR_WIDTH'(1);
                end
            end
            ST_READY: begin
                if (bus.clear_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Later ports overwrite earlier ones in the loop, so the highest port wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_ptr[IDX_W-1:0]] <= '0;
            end else begin
                for (int p = 0; p < WR_PORTS; p++) begin
                    if (w_wr_ok[p]) begin
                        r_mem[w_wr_idx[p]] <= w_wr_data[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_conflict <= 1'b0;
            r_err_oob  <= 1'b0;
        end else begin
            r_conflict <= w_is_ready && w_collision;
            if (w_is_ready && w_oob_any) begin
                r_err_oob <= 1'b1;
            end else if (bus.err_clr) begin
                r_err_oob <= 1'b0;
            end
        end
    end

    generate
        for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_port
            logic [ADDR_WIDTH-1:0] w_rd_addr;
            logic                  w_rd_ok;
            assign w_rd_addr = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_rd_ok   = w_is_ready && ({1'b0, w_rd_addr} < c_DEPTH);
            assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
                w_rd_ok ? r_mem[w_rd_addr[IDX_W-1:0]] : '0;
        end
    endgenerate

    assign bus.ready       = w_is_ready;
    assign bus.wr_conflict = r_conflict;
    assign bus.err_oob     = r_err_oob;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_mp
// Brief    : Directed table, corner sequences and randomized model check.
// Revision : 1.0
// ============================================================================
module tb_data_memory_mp;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int ND = 16;
    localparam int NP = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    data_memory_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_PORTS(NP), .WR_PORTS(NP)) bus ();

    data_memory_mp #(
        .DATA_WIDTH(DW), .DEPTH(ND), .ADDR_WIDTH(AW), .RD_PORTS(NP), .WR_PORTS(NP)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [3:0]      en;
        logic [3:0][4:0] wa;
        logic [3:0][7:0] wd;
        logic [3:0][4:0] ra;
        logic            clr;
        logic            eclr;
        logic [3:0][7:0] exp_rd;
        logic            exp_conf;
        logic            exp_oob;
    } vec_t;

    vec_t tbl [11];

    // Reference: memory as a plain array, clearing tracked as a word count.
    logic [7:0] m_mem [ND];
    bit         m_ready = 0;
    int         m_cnt   = 0;
    bit         m_conf  = 0;
    bit         m_oob   = 0;

    task automatic model_edge();
        bit hit [ND];
        bit conf;
        bit oob_set;
        int a;
        for (int i = 0; i < ND; i++) hit[i] = 0;
        conf    = 0;
        oob_set = 0;
        if (!reset) begin
            m_ready = 0; m_cnt = 0; m_conf = 0; m_oob = 0;
            return;
        end
        if (!m_ready) begin
            m_mem[m_cnt] = 8'h00;
            m_cnt++;
            if (m_cnt == ND) m_ready = 1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (bus.wr_en[p]) begin
                    a = int'(bus.wr_addr[p*AW +: AW]);
                    if (a < ND) begin
                        if (hit[a]) conf = 1;
                        hit[a]   = 1;
                        m_mem[a] = bus.wr_data[p*DW +: DW];
                    end else begin
                        oob_set = 1;
                    end
                end
            end
            if (bus.clear_req) begin
                m_ready = 0;
                m_cnt   = 0;
            end
        end
        m_conf = conf;
        m_oob  = oob_set || (m_oob && !bus.err_clr);
    endtask

    function automatic logic [7:0] model_rd(int a);
        return (m_ready && a < ND) ? m_mem[a] : 8'h00;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr   = '0;
        bus.clear_req = 1'b0;
        bus.err_clr   = 1'b0;
    endtask

    task automatic check_model(string tag);
        chk({tag, " ready"}, bus.ready, m_ready);
        chk({tag, " conflict"}, bus.wr_conflict, m_conf);
        chk({tag, " oob"}, bus.err_oob, m_oob);
        for (int p = 0; p < NP; p++)
            chk($sformatf("%s rd%0d", tag, p), bus.rd_data[p*DW +: DW],
                model_rd(int'(bus.rd_addr[p*AW +: AW])));
    endtask

    initial begin
        // Fields: en, wa{p3..p0}, wd{p3..p0}, ra{p3..p0}, clr, eclr, exp_rd{p3..p0}, conf, oob
        tbl[0]  = '{4'b1111, {5'd4,5'd3,5'd2,5'd1}, {8'h44,8'h33,8'h22,8'h11}, {5'd1,5'd2,5'd3,5'd4},
                    1'b0, 1'b0, {8'h11,8'h22,8'h33,8'h44}, 1'b0, 1'b0};
        tbl[1]  = '{4'b1101, {5'd5,5'd5,5'd0,5'd5}, {8'hC0,8'hB0,8'h00,8'hA0}, {5'd3,5'd2,5'd1,5'd5},
                    1'b0, 1'b0, {8'h33,8'h22,8'h11,8'hC0}, 1'b1, 1'b0};
        tbl[2]  = '{4'b0000, '0, '0, {5'd5,5'd5,5'd5,5'd5},
                    1'b0, 1'b0, {8'hC0,8'hC0,8'hC0,8'hC0}, 1'b0, 1'b0};
        tbl[3]  = '{4'b0010, {5'd0,5'd0,5'd20,5'd0}, {8'h00,8'h00,8'h5A,8'h00}, {5'd4,5'd5,5'd1,5'd20},
                    1'b0, 1'b0, {8'h44,8'hC0,8'h11,8'h00}, 1'b0, 1'b1};
        tbl[4]  = '{4'b0000, '0, '0, {5'd15,5'd0,5'd3,5'd2},
                    1'b0, 1'b0, {8'h00,8'h00,8'h33,8'h22}, 1'b0, 1'b1};
        tbl[5]  = '{4'b0000, '0, '0, {5'd4,5'd3,5'd2,5'd1},
                    1'b0, 1'b1, {8'h44,8'h33,8'h22,8'h11}, 1'b0, 1'b0};
        tbl[6]  = '{4'b1000, {5'd31,5'd0,5'd0,5'd0}, {8'h77,8'h00,8'h00,8'h00}, {5'd31,5'd16,5'd5,5'd4},
                    1'b0, 1'b1, {8'h00,8'h00,8'hC0,8'h44}, 1'b0, 1'b1};
        tbl[7]  = '{4'b0000, '0, '0, {5'd31,5'd16,5'd5,5'd4},
                    1'b0, 1'b1, {8'h00,8'h00,8'hC0,8'h44}, 1'b0, 1'b0};
        tbl[8]  = '{4'b1011, {5'd8,5'd0,5'd8,5'd7}, {8'h20,8'h00,8'h10,8'hFF}, {5'd1,5'd0,5'd8,5'd7},
                    1'b0, 1'b0, {8'h11,8'h00,8'h20,8'hFF}, 1'b1, 1'b0};
        tbl[9]  = '{4'b0011, {5'd0,5'd0,5'd20,5'd20}, {8'h00,8'h00,8'hAA,8'hBB}, {5'd0,5'd0,5'd0,5'd20},
                    1'b0, 1'b0, '0, 1'b0, 1'b1};
        tbl[10] = '{4'b0000, '0, '0, {5'd5,5'd4,5'd8,5'd7},
                    1'b0, 1'b1, {8'hC0,8'h44,8'h20,8'hFF}, 1'b0, 1'b0};

        idle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst ready", bus.ready, 1'b0);
            chk("rst conflict", bus.wr_conflict, 1'b0);
            chk("rst oob", bus.err_oob, 1'b0);
            chk("rst rd0", bus.rd_data[0 +: DW], 8'h00);
        end

        reset = 1'b1;
        for (int e = 1; e <= ND; e++) begin
            tick();
            chk($sformatf("init clear edge%0d ready", e), bus.ready, (e == ND));
        end
        for (int base = 0; base < ND; base += NP) begin
            for (int p = 0; p < NP; p++) bus.rd_addr[p*AW +: AW] = AW'(base + p);
            #1;
            for (int p = 0; p < NP; p++)
                chk($sformatf("init addr%0d", base + p), bus.rd_data[p*DW +: DW], 8'h00);
        end

        foreach (tbl[i]) begin
            bus.wr_en     = tbl[i].en;
            bus.wr_addr   = tbl[i].wa;
            bus.wr_data   = tbl[i].wd;
            bus.rd_addr   = tbl[i].ra;
            bus.clear_req = tbl[i].clr;
            bus.err_clr   = tbl[i].eclr;
            tick();
            chk($sformatf("tbl%0d ready", i), bus.ready, 1'b1);
            chk($sformatf("tbl%0d conflict", i), bus.wr_conflict, tbl[i].exp_conf);
            chk($sformatf("tbl%0d oob", i), bus.err_oob, tbl[i].exp_oob);
            for (int p = 0; p < NP; p++)
                chk($sformatf("tbl%0d rd%0d", i, p), bus.rd_data[p*DW +: DW], tbl[i].exp_rd[p]);
        end

        // Software clear with a write in the request cycle, then dropped writes.
        idle();
        bus.clear_req       = 1'b1;
        bus.wr_en           = 4'b0001;
        bus.wr_addr[0 +: AW] = 5'd8;
        bus.wr_data[0 +: DW] = 8'h12;
        bus.rd_addr         = {5'd7, 5'd7, 5'd8, 5'd8};
        tick();
        chk("swclr ready", bus.ready, 1'b0);
        chk("swclr rd0", bus.rd_data[0 +: DW], 8'h00);
        chk("swclr rd2", bus.rd_data[2*DW +: DW], 8'h00);
        bus.clear_req = 1'b0;
        bus.wr_en     = 4'b1111;
        bus.wr_addr   = {5'd0, 5'd9, 5'd25, 5'd9};
        bus.wr_data   = {8'h99, 8'h55, 8'h5A, 8'h99};
        for (int e = 1; e <= ND; e++) begin
            tick();
            chk($sformatf("swclr edge%0d ready", e), bus.ready, (e == ND));
            chk($sformatf("swclr edge%0d conflict", e), bus.wr_conflict, 1'b0);
            chk($sformatf("swclr edge%0d oob", e), bus.err_oob, 1'b0);
        end
        idle();
        bus.rd_addr = {5'd9, 5'd8, 5'd7, 5'd0};
        #1;
        for (int p = 0; p < NP; p++)
            chk($sformatf("swclr after rd%0d", p), bus.rd_data[p*DW +: DW], 8'h00);

        // Reset asserted on the sixth clear edge restarts the full sequence.
        bus.clear_req = 1'b1;
        tick();
        chk("midclr start ready", bus.ready, 1'b0);
        bus.clear_req = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        reset = 1'b0;
        tick();
        chk("midclr reset ready", bus.ready, 1'b0);
        reset = 1'b1;
        for (int e = 1; e <= ND; e++) begin
            tick();
            chk($sformatf("midclr edge%0d ready", e), bus.ready, (e == ND));
        end

        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 99) != 0);
            bus.wr_en     = 4'($urandom);
            bus.wr_data   = 32'($urandom);
            for (int p = 0; p < NP; p++) begin
                bus.wr_addr[p*AW +: AW] = AW'($urandom_range(0, 19));
                bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, 20));
            end
            bus.clear_req = ($urandom_range(0, 39) == 0);
            bus.err_clr   = ($urandom_range(0, 7) == 0);
            tick();
            check_model($sformatf("rand%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory_mp.md
# data_memory_mp

Parametrised multi-port data memory, the next-generation data store for the pipelined core's memory stage. It provides `RD_PORTS` combinational read ports and `WR_PORTS` clocked write ports over a `DEPTH` × `DATA_WIDTH` array. It adds a hardware clear sequencer (reset or software request), a `ready` indication, defined write-collision priority with a conflict flag, and out-of-range write detection.

## Interface
- `DATA_WIDTH`, 8: bits per word.
- `DEPTH`, 128: number of words; any value ≥ 2, not necessarily a power of two.
- `ADDR_WIDTH`, 8: address bits per port; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- `RD_PORTS`, 4: number of read ports (≥ 1).
- `WR_PORTS`, 4: number of write ports (≥ 1).

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clock` rising edge.
- `rd_addr`  in  RD_PORTS*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rd_data`  out  RD_PORTS*DATA_WIDTH  read data, port i at [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_addr`  in  WR_PORTS*ADDR_WIDTH  write addresses, packed as for reads.
- `wr_data`  in  WR_PORTS*DATA_WIDTH  write data.
- `wr_en`  in  WR_PORTS  per-port write enable; bit i belongs to port i.
- `clear_req`  in  1  single-cycle request to re-clear the whole array.
- `ready`  out  1  array is cleared and accepting writes.
- `wr_conflict`  out  1  registered pulse: a same-address write collision occurred on the previous edge.
- `err_oob`  out  1  sticky: an enabled write used an address ≥ DEPTH.
- `err_clr`  in  1  clears `err_oob`.

## Operation
- Two states: `CLEAR` and `READY`. A clear pointer `clr_ptr` (ADDR_WIDTH bits) walks the array.
- `reset` low at an edge sets the following:
  - state = CLEAR, `clr_ptr` = 0;
  - `ready` = 0, `wr_conflict` = 0, `err_oob` = 0.
  - Array contents are not touched while reset is held.
- CLEAR behaviour, at each edge:
  - write 0 to `mem[clr_ptr]`;
  - if `clr_ptr` == DEPTH-1, go to READY and set `ready` = 1; otherwise increment `clr_ptr`.
  - All `wr_en` are ignored: writes are dropped, no conflict flag, no oob flag.
  - `clear_req` is ignored.
- READY behaviour:
  - Each enabled write port with address < DEPTH writes its data at the edge.
  - An enabled write with address ≥ DEPTH is dropped and sets `err_oob` = 1.
  - Collision: when two or more enabled, in-range ports target the same address, the highest-numbered port wins.
  - `wr_conflict` is 1 for exactly the cycle after any collision edge, otherwise 0.
- `clear_req` = 1 in READY:
  - writes presented in that same cycle are still performed;
  - then state = CLEAR, `clr_ptr` = 0, `ready` = 0.
- `err_clr` = 1 clears `err_oob` at the edge. If a new oob write occurs on the same edge, the set wins (`err_oob` = 1).
- Reads (combinational):
  - `rd_data[i]` = `mem[rd_addr[i]]` when state = READY and `rd_addr[i]` < DEPTH;
  - `rd_data[i]` = 0 otherwise, i.e. in CLEAR or for an out-of-range address.

## Timing
- Reset values: `ready` = 0, `wr_conflict` = 0, `err_oob` = 0; `rd_data` = all 0 because the state is CLEAR.
- Clear duration:
  - If `reset` is first high at edge k, `mem[0..DEPTH-1]` is cleared on edges k..k+DEPTH-1.
  - `ready` = 1 after edge k+DEPTH-1, i.e. exactly DEPTH cycles.
  - The same DEPTH-cycle count applies after `clear_req`.
- Read latency is 0 cycles (combinational). A read in the same cycle as a write to that address returns the old value; the new value appears the cycle after the write edge.
- Reset mid-clear: `clr_ptr` returns to 0 and the full DEPTH-cycle sequence restarts.
- Reset in READY: the sequence restarts and `ready` drops at that edge.
- Any number of ports may write in one cycle. There is no back-pressure; `ready` = 0 is the only indication that writes are being dropped.

## Test plan
All scenarios use DEPTH = 16, ADDR_WIDTH = 5, DATA_WIDTH = 8, RD_PORTS = WR_PORTS = 4.
- Reset release clear: hold `reset` low 3 cycles, then release -> `ready` = 0 for 16 edges and = 1 after the 16th; all 16 addresses then read 0x00 on every port.
- Parallel writes: in READY, ports 0–3 write 0x11/0x22/0x33/0x44 to addresses 1/2/3/4 in one cycle -> next cycle `rd_addr` = {4,3,2,1} returns {0x44,0x33,0x22,0x11}; `wr_conflict` = 0.
- Collision priority: ports 0, 2, 3 all write address 5 with 0xA0/0xB0/0xC0 -> address 5 reads 0xC0; `wr_conflict` = 1 for one cycle, then 0.
- Out-of-range write:
  - port 1 writes address 20 with 0x5A -> `err_oob` = 1 and stays 1; `rd_addr` = 20 reads 0x00; addresses 0–15 are unchanged;
  - `err_clr` pulse -> `err_oob` = 0;
  - `err_clr` on the same edge as a new oob write -> `err_oob` stays 1.
- Software clear:
  - array holds 0xFF at address 7; assert `clear_req` while port 0 writes 0x12 to address 8 -> address 8 is written, then `ready` = 0;
  - reads return 0 and a write of 0x99 to address 9 during CLEAR is dropped;
  - after 16 edges `ready` = 1, and addresses 7, 8, 9 all read 0x00.
- Reset mid-clear: assert `reset` low for 1 cycle at clear edge 6 -> `ready` rises only 16 edges after the release, not 10.
